// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side endpoint of a command/response FIFO pair. Pops 17-bit commands
//   from a first-word-fall-through command FIFO and executes them against an
//   internal 256 x 8 register memory. Read results are pushed into the
//   response FIFO. After every reset, a sweep clears the memory to INIT_VALUE
//   before any command is accepted.
//
// Parameters
//   INIT_VALUE       value written to every location by the clear sweep
//
// Ports
//   clk              memory-domain clock
//   rst_n            asynchronous active-low reset
//   cmd_fifo_rd_en   pop strobe to the command FIFO (one-cycle pulse per command)
//   cmd_fifo_data    {op, addr[7:0], wdata[7:0]}; op 1 = write, 0 = read
//   cmd_fifo_empty   command FIFO empty
//   resp_fifo_wr_en  push strobe to the response FIFO (one-cycle pulse per read)
//   resp_fifo_data   read result, valid while resp_fifo_wr_en is high
//   resp_fifo_full   response FIFO full
//   ready            high once the clear sweep has finished
//   write_count      writes executed, modulo 256
//   read_count       read responses pushed, modulo 256
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter logic [7:0] INIT_VALUE = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        cmd_fifo_rd_en,
  input  logic [16:0] cmd_fifo_data,
  input  logic        cmd_fifo_empty,
  output logic        resp_fifo_wr_en,
  output logic [7:0]  resp_fifo_data,
  input  logic        resp_fifo_full,
  output logic        ready,
  output logic [7:0]  write_count,
  output logic [7:0]  read_count
);

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned CW    = 1 + AW + DW;
  localparam int unsigned DEPTH = 1 << AW;

  // Command field positions
  localparam int unsigned OP_BIT = CW - 1;
  localparam int unsigned A_MSB  = AW + DW - 1;
  localparam int unsigned A_LSB  = DW;
  localparam int unsigned D_MSB  = DW - 1;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e          state_q,     state_d;
  logic [CW-1:0]   cmd_q,       cmd_d;
  logic [DW-1:0]   rdata_q,     rdata_d;
  logic [AW-1:0]   clr_addr_q,  clr_addr_d;
  logic            rd_en_q,     rd_en_d;
  logic            wr_en_q,     wr_en_d;
  logic [DW-1:0]   resp_data_q, resp_data_d;
  logic            ready_q,     ready_d;
  logic [DW-1:0]   wcnt_q,      wcnt_d;
  logic [DW-1:0]   rcnt_q,      rcnt_d;

  // Register memory; contents are only ever defined by the clear sweep or writes
  logic [DW-1:0]   mem_q [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [DW-1:0]   mem_wdata;

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rdata_d     = rdata_q;
    clr_addr_d  = clr_addr_q;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    resp_data_d = resp_data_q;
    ready_d     = ready_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;

    unique case (state_q)
      ST_INIT: begin
        // One location cleared per cycle; the command FIFO is left alone
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = INIT_VALUE;
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == {AW{1'b1}}) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (!cmd_fifo_empty) begin
          cmd_d   = cmd_fifo_data;
          rd_en_d = 1'b1;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // The pop strobe is high during this cycle, so the FIFO flags have
        // settled by the time IDLE next looks at them.
        if (cmd_q[OP_BIT]) begin
          mem_we    = 1'b1;
          mem_waddr = cmd_q[A_MSB:A_LSB];
          mem_wdata = cmd_q[D_MSB:0];
          wcnt_d    = wcnt_q + DW'(1);
          state_d   = ST_IDLE;
        end else begin
          rdata_d = mem_q[cmd_q[A_MSB:A_LSB]];
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        // Backpressure holds everything, including the command stream
        if (!resp_fifo_full) begin
          resp_data_d = rdata_q;
          wr_en_d     = 1'b1;
          rcnt_d      = rcnt_q + DW'(1);
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d    = ST_INIT;
        ready_d    = 1'b0;
        clr_addr_d = '0;
      end
    endcase
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cmd_q       <= '0;
      rdata_q     <= '0;
      clr_addr_q  <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      resp_data_q <= '0;
      ready_q     <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rdata_q     <= rdata_d;
      clr_addr_q  <= clr_addr_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      resp_data_q <= resp_data_d;
      ready_q     <= ready_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
    end
  end

  // Memory array has no reset; the sweep after reset initialises it
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign cmd_fifo_rd_en  = rd_en_q;
  assign resp_fifo_wr_en = wr_en_q;
  assign resp_fifo_data  = resp_data_q;
  assign ready           = ready_q;
  assign write_count     = wcnt_q;
  assign read_count      = rcnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a queue models the FWFT command FIFO, a scoreboard
// queue holds expected read responses, and a vector table drives the main
// write/read traffic. Hand-written sequences cover latency, backpressure,
// reset in RESP and back-to-back write throughput.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_fifo_rd_en;
  logic [16:0] cmd_fifo_data;
  logic        cmd_fifo_empty;
  logic        resp_fifo_wr_en;
  logic [7:0]  resp_fifo_data;
  logic        resp_fifo_full;
  logic        ready;
  logic [7:0]  write_count;
  logic [7:0]  read_count;

  always #5 clk = ~clk;

  mem_responder #(.INIT_VALUE(8'h00)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_fifo_rd_en  (cmd_fifo_rd_en),
    .cmd_fifo_data   (cmd_fifo_data),
    .cmd_fifo_empty  (cmd_fifo_empty),
    .resp_fifo_wr_en (resp_fifo_wr_en),
    .resp_fifo_data  (resp_fifo_data),
    .resp_fifo_full  (resp_fifo_full),
    .ready           (ready),
    .write_count     (write_count),
    .read_count      (read_count)
  );

  typedef struct {
    logic       op;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [16:0] cmdq[$];
  logic [7:0]  expq[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  wr_cnt = 8'h00;
  logic [7:0]  rd_cnt = 8'h00;
  logic        prev_rd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    if (cmdq.size() == 0) begin
      cmd_fifo_empty = 1'b1;
      cmd_fifo_data  = '0;
    end else begin
      cmd_fifo_empty = 1'b0;
      cmd_fifo_data  = cmdq[0];
    end
  endtask

  // Queue a command; reads with want_resp push their expected data
  task automatic push_cmd(input logic op, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp, input bit want_resp);
    cmdq.push_back({op, addr, wdata});
    if (op) wr_cnt = wr_cnt + 8'd1;
    else if (want_resp) begin
      expq.push_back(exp);
      rd_cnt = rd_cnt + 8'd1;
    end
    drive_fifo();
  endtask

  // Advance one cycle; sample at the falling edge and model the FIFOs
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (cmd_fifo_rd_en) begin
      if (cmdq.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_when_empty: rd_en=1 with empty FIFO (t=%0t)", $time);
      end else begin
        void'(cmdq.pop_front());
      end
      if (prev_rd) begin
        checks++; errors++;
        $display("FAIL rd_en_pulse: rd_en high two cycles in a row (t=%0t)", $time);
      end
    end
    prev_rd = cmd_fifo_rd_en;
    if (resp_fifo_wr_en) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got %0h expected no push (t=%0t)", resp_fifo_data, $time);
      end else begin
        e = expq.pop_front();
        chk("resp_data", resp_fifo_data, e);
      end
    end
    drive_fifo();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((cmdq.size() != 0 || expq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL drain_timeout: cmdq=%0d expq=%0d after %0d cycles", cmdq.size(), expq.size(), n);
    end
    repeat (3) tick();
  endtask

  task automatic wait_ready(input string name);
    for (int i = 1; i <= 256; i++) begin
      tick();
      chk(name, ready, (i == 256) ? 1 : 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, cmd_fifo_rd_en, 0);
    chk({tag, "_wr_en"}, resp_fifo_wr_en, 0);
    chk({tag, "_resp_data"}, resp_fifo_data, 8'h00);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_write_count"}, write_count, 8'h00);
    chk({tag, "_read_count"}, read_count, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v;
    logic [7:0] a;

    rst_n          = 1'b0;
    resp_fifo_full = 1'b0;
    drive_fifo();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");

    // Clear sweep: ready exactly 256 edges after release
    rst_n = 1'b1;
    wait_ready("ready_rise");

    // Read-accept latency: rd_en in EXEC, push three cycles after acceptance
    push_cmd(1'b1, 8'h55, 8'hC3, 8'h00, 1'b0);
    wait_idle(50);
    push_cmd(1'b0, 8'h55, 8'h00, 8'hC3, 1'b1);
    tick(); chk("lat_rd_en_exec", cmd_fifo_rd_en, 1);
    chk("lat_wr_en_exec", resp_fifo_wr_en, 0);
    tick(); chk("lat_wr_en_resp", resp_fifo_wr_en, 0);
    chk("lat_rd_en_resp", cmd_fifo_rd_en, 0);
    tick(); chk("lat_wr_en_push", resp_fifo_wr_en, 1);
    tick(); chk("lat_wr_en_single", resp_fifo_wr_en, 0);

    // Vector table: default read, write/read, sixteen write/read pairs
    vecs.push_back('{op: 1'b0, addr: 8'h10, wdata: 8'h00, exp: 8'h00});
    vecs.push_back('{op: 1'b1, addr: 8'h10, wdata: 8'h6A, exp: 8'h00});
    vecs.push_back('{op: 1'b0, addr: 8'h10, wdata: 8'h00, exp: 8'h6A});
    for (int k = 1; k <= 16; k++) begin
      a = 8'(16 * k);
      vecs.push_back('{op: 1'b1, addr: a, wdata: a + 8'h5A, exp: 8'h00});
      vecs.push_back('{op: 1'b0, addr: a, wdata: 8'h00, exp: a + 8'h5A});
    end
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      push_cmd(v.op, v.addr, v.wdata, v.exp, 1'b1);
    end
    wait_idle(500);
    chk("table_write_count", write_count, 8'd18);
    chk("table_read_count", read_count, 8'd19);

    // Backpressure: park in RESP with more commands queued
    resp_fifo_full = 1'b1;
    push_cmd(1'b0, 8'h20, 8'h00, 8'h7A, 1'b1);
    tick(); tick();
    push_cmd(1'b1, 8'h30, 8'h11, 8'h00, 1'b0);
    push_cmd(1'b0, 8'h30, 8'h00, 8'h11, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_rd_en", cmd_fifo_rd_en, 0);
      chk("hold_wr_en", resp_fifo_wr_en, 0);
    end
    chk("hold_queue_intact", cmdq.size(), 2);
    resp_fifo_full = 1'b0;
    tick(); chk("release_push", resp_fifo_wr_en, 1);
    tick(); chk("release_single", resp_fifo_wr_en, 0);
    wait_idle(100);
    chk("bp_write_count", write_count, wr_cnt);
    chk("bp_read_count", read_count, rd_cnt);

    // Reset while parked in RESP: response dropped, memory swept again
    resp_fifo_full = 1'b1;
    push_cmd(1'b1, 8'h40, 8'h99, 8'h00, 1'b0);
    push_cmd(1'b0, 8'h40, 8'h00, 8'h00, 1'b0);
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    cmdq.delete();
    expq.delete();
    wr_cnt = 8'h00;
    rd_cnt = 8'h00;
    resp_fifo_full = 1'b0;
    drive_fifo();
    repeat (2) tick();
    rst_n = 1'b1;
    wait_ready("ready_rerun");
    push_cmd(1'b0, 8'h40, 8'h00, 8'h00, 1'b1);
    push_cmd(1'b0, 8'h10, 8'h00, 8'h00, 1'b1);
    push_cmd(1'b0, 8'h20, 8'h00, 8'h00, 1'b1);
    wait_idle(100);
    chk("rst_write_count", write_count, 8'h00);
    chk("rst_read_count", read_count, 8'd3);

    // 256 back-to-back writes: rd_en on every second cycle, count wraps
    for (int i = 0; i < 256; i++) begin
      push_cmd(1'b1, 8'(i), 8'(i) ^ 8'hA5, 8'h00, 1'b0);
    end
    for (int t = 1; t <= 512; t++) begin
      tick();
      chk("b2b_rd_en", cmd_fifo_rd_en, (t % 2 == 1) ? 1 : 0);
      if (t == 510) chk("b2b_count_ff", write_count, 8'hFF);
    end
    chk("b2b_count_wrap", write_count, 8'h00);
    push_cmd(1'b0, 8'h00, 8'h00, 8'hA5, 1'b1);
    push_cmd(1'b0, 8'hFF, 8'h00, 8'h5A, 1'b1);
    push_cmd(1'b0, 8'h7E, 8'h00, 8'hDB, 1'b1);
    wait_idle(100);
    chk("final_write_count", write_count, wr_cnt);
    chk("final_read_count", read_count, 8'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side endpoint of the command/response FIFO pair driven by the 90 MHz test master. It pops 17-bit commands from the command async FIFO, executes them against an internal 256 x 8 register memory, and pushes read results into the response async FIFO. It sits in the memory clock domain, between the read port of the command FIFO and the write port of the response FIFO.

## Interface
- INIT_VALUE, 8'h00, value written to every memory location by the post-reset clear sweep
- clk  in  1  memory-domain clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_fifo_rd_en  out  1  pop strobe to command FIFO; one-cycle pulse per command
- cmd_fifo_data  in  17  [16] op (0=read, 1=write), [15:8] address, [7:0] write data; first-word-fall-through, valid while !cmd_fifo_empty
- cmd_fifo_empty  in  1  command FIFO empty
- resp_fifo_wr_en  out  1  push strobe to response FIFO; one-cycle pulse per read
- resp_fifo_data  out  8  read result; valid in the cycle resp_fifo_wr_en is high
- resp_fifo_full  in  1  response FIFO full
- ready  out  1  high once the clear sweep is complete; commands accepted only when high
- write_count  out  8  writes executed, wraps 8'hFF -> 8'h00
- read_count  out  8  read responses pushed, wraps 8'hFF -> 8'h00

## Operation
- States: INIT, IDLE, EXEC, RESP.
- INIT: `clr_addr` starts at 0. Each cycle: write mem[clr_addr] <= INIT_VALUE, then clr_addr++. After writing address 8'hFF: ready <= 1, go to IDLE. The command FIFO is not touched in INIT.
- IDLE: if !cmd_fifo_empty:
  - latch cmd_fifo_data into cmd_q
  - cmd_fifo_rd_en <= 1
  - go to EXEC
  - Otherwise stay in IDLE.
- EXEC: cmd_fifo_rd_en is high in this cycle, and the pop takes effect at the end of it.
  - Write (cmd_q[16]=1): mem[cmd_q[15:8]] <= cmd_q[7:0]; write_count++; go to IDLE.
  - Read (cmd_q[16]=0): rdata_q <= mem[cmd_q[15:8]]; go to RESP. cmd_q[7:0] is ignored.
- RESP: if !resp_fifo_full:
  - resp_fifo_data <= rdata_q
  - resp_fifo_wr_en <= 1
  - read_count++
  - go to IDLE
  - Otherwise hold in RESP. No further command is popped while holding.
- Default every cycle: cmd_fifo_rd_en <= 0 and resp_fifo_wr_en <= 0. Both are only ever single-cycle pulses.
- Addresses are the full 8 bits; no out-of-range case exists. Counters are 8-bit modulo.
- Undefined state -> INIT, with ready <= 0.

## Timing
- Reset values:
  - cmd_fifo_rd_en = 0, resp_fifo_wr_en = 0
  - resp_fifo_data = 8'h00
  - ready = 0
  - write_count = 0, read_count = 0
  - state = INIT, clr_addr = 0
  - Memory contents are not reset asynchronously; the INIT sweep overwrites them.
- ready rises exactly 256 clock edges after rst_n deasserts.
- Write command: 2 cycles (IDLE, EXEC). Sustained throughput is 1 write per 2 cycles.
- Read command: 3 cycles minimum (IDLE, EXEC, RESP). resp_fifo_wr_en is asserted in the cycle after RESP, i.e. 3 cycles after the IDLE cycle that accepted the command.
- IDLE is never re-entered while cmd_fifo_rd_en is still high. The FIFO's empty flag therefore reflects the pop before the next acceptance decision.
- Read-after-write to the same address returns the new data. The write commits at the end of EXEC, before any later EXEC.
- resp_fifo_full: the block stalls in RESP indefinitely, and rdata_q and the command stream are frozen. Exactly one push follows the cycle full deasserts.
- cmd_fifo_empty while in EXEC or RESP is ignored.
- Reset mid-operation (any state): all outputs return to their reset values immediately, and an in-flight command is dropped. A latched-but-unpopped command remains in the FIFO and is re-executed after INIT. INIT reruns in full.

## Test plan
- Release reset, keep the FIFO empty -> ready=0 for 256 edges, then 1. A read of 0x10 then returns 8'h00 (INIT_VALUE default); read_count=1.
- Write 0x10<-0x6A, then read 0x10 -> one response 0x6A; write_count=1, read_count=1. resp_fifo_wr_en is high exactly 3 cycles after the read was accepted.
- Sixteen write/read pairs at addr = 0x10*k mod 256 (k=1..16, last addr 0x00), data = addr+0x5A -> responses in order 0x6A, 0x7A, ..., 0x4A, 0x5A; write_count=16, read_count=16.
- Read 0x20 with resp_fifo_full held high for 10 cycles and further commands queued -> no wr_en and no cmd_fifo_rd_en during the hold. One push of the correct data follows full deasserting, then the queued commands proceed.
- Assert rst_n low while in RESP -> wr_en never pulses, outputs are zeroed, ready=0. INIT reruns (256 cycles) and previously written data reads back as 8'h00.
- 256 back-to-back writes with the FIFO always non-empty -> cmd_fifo_rd_en pulses every 2nd cycle, and write_count wraps to 8'h00.
